mux_select_scheduler: RTL and testbench

- Sequences the 3-bit video-mux select from 5 front-panel buttons and one override switch.
- Debounces and synchronizes the inputs and arbitrates simultaneous presses by fixed priority.
- Defers every select change to a frame boundary (rising vsync) so the mux never switches mid-frame.
- Sits between the board I/O and the video source mux.

---
 rtl/mux_ctrl_pkg.sv | 37 +++
 rtl/input_debounce.sv | 58 +++++
 rtl/mux_select_scheduler.sv | 162 ++++++++++++++++
 tb/tb_mux_select_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the video-mux select scheduler.
// Contains the select code type, the one-hot FSM state type, the default debounce length,
// and small helpers for choosing and advancing select codes.
package mux_ctrl_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_NONE = 3'd0;
    localparam sel_t SEL_MAX  = 3'd5;

    // One-hot encoding keeps each state decode to a single flop.
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        WAIT   = 3'b010,
        COMMIT = 3'b100
    } state_t;

    localparam logic [15:0] DEBOUNCE_CYCLES_DEFAULT = 16'd50000;

    // Lowest set bit wins: bit i maps to select code i+1; no bits set gives SEL_NONE.
    function automatic sel_t first_press_code(input logic [4:0] events);
        sel_t code;
        code = SEL_NONE;
        for (int i = 4; i >= 0; i--) begin
            if (events[i]) begin
                code = sel_t'(i + 1);
            end
        end
        return code;
    endfunction

    // Next source in round-robin order 1..SEL_MAX, wrapping back to 1.
    function automatic sel_t next_code(input sel_t cur);
        return (cur >= SEL_MAX) ? sel_t'(1) : sel_t'(cur + 3'd1);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a per-bit debouncer.
// A bit's accepted value changes only after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module input_debounce
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 1,
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0]       sync1_q;
    logic [WIDTH-1:0]       sync2_q;
    logic [WIDTH-1:0]       stable_q;
    logic [WIDTH-1:0]       stable_d;
    logic [WIDTH-1:0][15:0] cnt_q;
    logic [WIDTH-1:0][15:0] cnt_d;

    // Count consecutive disagreeing cycles per bit and accept the new level when the count completes.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= DEBOUNCE_CYCLES - 16'd1) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Synchronizer chain, debounce counters and accepted values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/mux_select_scheduler.sv
// Video-mux select scheduler: turns debounced button presses and an override switch into a
// select code, and only lets the committed select change on a rising vsync frame boundary.
// Optional auto-advance (macro MUX_AUTO_CYCLE_EN) steps to the next source after AUTO_FRAMES idle frames.
module mux_select_scheduler
    import mux_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter sel_t        OVERRIDE_SEL    = 3'd5
`ifdef MUX_AUTO_CYCLE_EN
    ,
    parameter logic [7:0]  AUTO_FRAMES     = 8'd120
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] buttons,
    input  logic       switch,
    input  logic       vsync,
    output logic [2:0] sel,
    output logic       sel_update,
    output logic       pending
);

    logic [4:0] btn_db;
    logic       sw_db;
    logic [4:0] btn_prev_q;
    logic       sw_prev_q;
    logic       vs_sync1_q;
    logic       vs_sync2_q;
    logic       vs_prev_q;
    logic [4:0] press;
    logic       sw_rise;
    logic       sw_fall;
    logic       fb;
    sel_t       press_code;
    logic       auto_fire;
    state_t     state_q, state_d;
    sel_t       sel_q, sel_d;
    sel_t       target_q, target_d;
    sel_t       saved_sel_q, saved_sel_d;

    input_debounce #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
        .clock (clock),
        .reset (reset),
        .din   (buttons),
        .dout  (btn_db)
    );

    input_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_debounce (
        .clock (clock),
        .reset (reset),
        .din   (switch),
        .dout  (sw_db)
    );

    assign press      = btn_db & ~btn_prev_q;
    assign sw_rise    = sw_db & ~sw_prev_q;
    assign sw_fall    = ~sw_db & sw_prev_q;
    assign fb         = vs_sync2_q & ~vs_prev_q;
    assign press_code = first_press_code(press);

`ifdef MUX_AUTO_CYCLE_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign auto_fire = (state_q == IDLE) && !sw_db && (frame_cnt_q == AUTO_FRAMES);

    // Count idle frame boundaries on a live source; any press or commit restarts the count.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if ((press != 5'd0) || (state_q == COMMIT) || auto_fire) begin
            frame_cnt_d = 8'd0;
        end else if (fb && (state_q == IDLE) && !sw_db && (sel_q != SEL_NONE)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Idle frame counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // Target selection: switch edges beat presses; presses are ignored while overridden or redundant.
    always_comb begin
        target_d    = target_q;
        saved_sel_d = saved_sel_q;
        if (sw_rise) begin
            saved_sel_d = sel_q;
            target_d    = OVERRIDE_SEL;
        end else if (sw_fall) begin
            target_d = saved_sel_q;
        end else if (!sw_db && (press != 5'd0) &&
                     !((press_code == sel_q) && (state_q != WAIT))) begin
            target_d = press_code;
        end else if (auto_fire) begin
            target_d = next_code(sel_q);
        end
    end

    // Scheduling FSM: wait for a frame boundary before committing, drop back if the target reverts.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (target_d != sel_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (target_d == sel_q) begin
                    state_d = IDLE;
                end else if (fb) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                sel_d   = target_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, select, edge-detect history and vsync synchronizer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_NONE;
            target_q    <= SEL_NONE;
            saved_sel_q <= SEL_NONE;
            btn_prev_q  <= 5'd0;
            sw_prev_q   <= 1'b0;
            vs_sync1_q  <= 1'b0;
            vs_sync2_q  <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            target_q    <= target_d;
            saved_sel_q <= saved_sel_d;
            btn_prev_q  <= btn_db;
            sw_prev_q   <= sw_db;
            vs_sync1_q  <= vsync;
            vs_sync2_q  <= vs_sync1_q;
            vs_prev_q   <= vs_sync2_q;
        end
    end

    assign sel        = sel_q;
    assign sel_update = (state_q == COMMIT);
    assign pending    = (state_q == WAIT);

endmodule

// File: tb/tb_mux_select_scheduler.sv
// Testbench for mux_select_scheduler with a short debounce length.
// An abstract model tracks committed select, target and pending request; each frame-boundary
// commit pushes the expected select into a queue that a monitor process pops on every sel_update.
module tb_mux_select_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] buttons = 5'd0;
    logic       switch = 1'b0;
    logic       vsync = 1'b0;
    logic [2:0] sel;
    logic       sel_update;
    logic       pending;

    int checks = 0;
    int errors = 0;

    int m_sel   = 0;
    int m_tgt   = 0;
    int m_saved = 0;
    int m_pend  = 0;
    int m_sw    = 0;
    int m_cnt   = 0;
    int exp_q[$];

    mux_select_scheduler #(
        .DEBOUNCE_CYCLES(16'd4),
        .OVERRIDE_SEL(3'd5)
`ifdef MUX_AUTO_CYCLE_EN
        ,
        .AUTO_FRAMES(8'd3)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .buttons    (buttons),
        .switch     (switch),
        .vsync      (vsync),
        .sel        (sel),
        .sel_update (sel_update),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_sel"}, int'(sel), m_sel);
        check_output({tag, "_pending"}, int'(pending), m_pend);
    endtask

    // Press a button mask long enough to debounce, then release it.
    task automatic do_press(input logic [4:0] mask);
        int code;
        code = 0;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i]) code = i + 1;
        end
`ifdef MUX_AUTO_CYCLE_EN
        m_cnt = 0;
`endif
        if (m_sw == 0 && !(m_pend == 0 && code == m_sel)) begin
            m_tgt  = code;
            m_pend = (m_tgt != m_sel) ? 1 : 0;
        end
        @(negedge clock);
        buttons = mask;
        repeat (10) @(negedge clock);
        buttons = 5'd0;
        repeat (10) @(negedge clock);
        check_state("press");
    endtask

    // One vsync pulse, i.e. one frame boundary.
    task automatic do_frame();
        if (m_pend != 0) begin
            exp_q.push_back(m_tgt);
            m_sel  = m_tgt;
            m_pend = 0;
            m_cnt  = 0;
        end
`ifdef MUX_AUTO_CYCLE_EN
        else if (m_sw == 0 && m_sel != 0) begin
            m_cnt++;
            if (m_cnt == 3) begin
                m_cnt  = 0;
                m_tgt  = (m_sel == 5) ? 1 : m_sel + 1;
                m_pend = 1;
            end
        end
`endif
        @(negedge clock);
        vsync = 1'b1;
        repeat (4) @(negedge clock);
        vsync = 1'b0;
        repeat (8) @(negedge clock);
        check_state("frame");
    endtask

    task automatic do_switch();
        m_sw = (m_sw == 0) ? 1 : 0;
        if (m_sw != 0) begin
            m_saved = m_sel;
            m_tgt   = 5;
        end else begin
            m_tgt = m_saved;
        end
        m_pend = (m_tgt != m_sel) ? 1 : 0;
        @(negedge clock);
        switch = (m_sw != 0);
        repeat (12) @(negedge clock);
        check_state("switch");
    endtask

    // Button 0 chatters faster than the debounce window and must never be accepted.
    task automatic do_bounce();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            buttons = (i % 2 == 0) ? 5'b00001 : 5'b00000;
            @(negedge clock);
        end
        buttons = 5'd0;
        repeat (10) @(negedge clock);
        check_state("bounce");
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        buttons = 5'd0;
        switch  = 1'b0;
        vsync   = 1'b0;
        #1;
        check_output("reset_sel", int'(sel), 0);
        check_output("reset_pending", int'(pending), 0);
        check_output("reset_sel_update", int'(sel_update), 0);
        m_sel = 0; m_tgt = 0; m_saved = 0; m_pend = 0; m_sw = 0; m_cnt = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        logic seen;
        int   exp_sel;
        seen = 1'b0;

        // Monitor: every sel_update pulse must match the next queued commit, checked once sel has moved.
        fork
            forever begin
                @(negedge clock);
                if (seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_update: got sel %0d expected no update at %0t", sel, $time);
                    end else begin
                        exp_sel = exp_q.pop_front();
                        check_output("committed_sel", int'(sel), exp_sel);
                    end
                end
                seen = sel_update && !reset;
            end
        join_none

        repeat (3) @(negedge clock);
        check_output("init_sel", int'(sel), 0);
        check_output("init_pending", int'(pending), 0);
        check_output("init_sel_update", int'(sel_update), 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        do_press(5'b00010);
        do_reset();
        do_frame();

        do_press(5'b00100);
        do_frame();

        do_press(5'b10010);
        do_frame();
        do_press(5'b10000);
        do_frame();
        do_press(5'b00001);
        do_press(5'b00100);
        do_frame();

        do_bounce();

        do_switch();
        do_press(5'b00001);
        do_frame();
        do_switch();
        do_frame();

        do_press(5'b10000);
        do_frame();
        do_frame();
        do_frame();
        do_frame();
        do_frame();

        for (int n = 0; n < 70; n++) begin
            int op;
            logic [4:0] mask;
            op = int'($urandom_range(0, 12));
            if (op <= 4) begin
                mask = 5'($urandom_range(1, 31));
                do_press(mask);
            end else if (op <= 8) begin
                do_frame();
            end else if (op <= 10) begin
                do_switch();
            end else if (op == 11) begin
                do_bounce();
            end else begin
                do_reset();
            end
        end

        repeat (6) @(negedge clock);
        check_output("leftover_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
